// File: rtl/game_minute_timer.sv
// Game clock for the game-state FSM: divides Clk into game-seconds and
// game-minutes, runs only while enabled, saturates at MAX_MIN and flags
// the time limit once LIMIT_MIN minutes have elapsed.
module game_minute_timer #(
   parameter int unsigned TICKS_PER_SEC = 1_666_667,
   parameter int unsigned SEC_PER_MIN   = 60,
   parameter int unsigned LIMIT_MIN     = 120,
   parameter int unsigned MAX_MIN       = 255
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Clear,
   input  logic       Run,
   output logic [7:0] minutes,
   output logic [5:0] seconds,
   output logic       min_tick,
   output logic       time_up,
   output logic       running
);

   localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
   localparam logic [5:0]    SEC_LAST  = 6'(SEC_PER_MIN - 1);
   localparam logic [7:0]    MIN_MAX   = 8'(MAX_MIN);
   localparam logic [7:0]    MIN_LIMIT = 8'(LIMIT_MIN);

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_PAUSE, ST_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_tick_cnt, w_tick_nxt;
   logic [5:0]    r_seconds, w_sec_nxt;
   logic [7:0]    r_minutes, w_min_nxt;
   logic          w_min_inc;
   logic          r_min_inc;
   logic          r_min_tick;
   logic          r_time_up;
   logic          r_running;

   // Next-state and counter update; Clear overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick_cnt;
      w_sec_nxt   = r_seconds;
      w_min_nxt   = r_minutes;
      w_min_inc   = 1'b0;
      if (Clear) begin
         w_state_nxt = ST_STOP;
         w_tick_nxt  = '0;
         w_sec_nxt   = '0;
         w_min_nxt   = '0;
      end else begin
         case (r_state)
            ST_STOP, ST_PAUSE: begin
               if (Run) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (!Run) begin
                  w_state_nxt = ST_PAUSE;
               end else if (r_tick_cnt == TICK_LAST) begin
                  w_tick_nxt = '0;
                  if (r_seconds == SEC_LAST) begin
                     w_sec_nxt = '0;
                     w_min_nxt = r_minutes + 8'd1;
                     w_min_inc = 1'b1;
                     if (w_min_nxt == MIN_MAX) begin
                        w_state_nxt = ST_DONE;
                        w_sec_nxt   = '0;
                        w_tick_nxt  = '0;
                     end
                  end else begin
                     w_sec_nxt = r_seconds + 6'd1;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_DONE;
            end
            default: begin
               w_state_nxt = ST_STOP;
            end
         endcase
      end
   end

   // State and output registers; min_tick trails the minutes increment by one
   // cycle, so the increment is staged through r_min_inc first
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= ST_STOP;
         r_tick_cnt <= '0;
         r_seconds  <= '0;
         r_minutes  <= '0;
         r_min_inc  <= 1'b0;
         r_min_tick <= 1'b0;
         r_time_up  <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_seconds  <= w_sec_nxt;
         r_minutes  <= w_min_nxt;
         r_min_inc  <= w_min_inc;
         r_min_tick <= Clear ? 1'b0 : r_min_inc;
         r_time_up  <= (w_min_nxt >= MIN_LIMIT);
         r_running  <= (w_state_nxt == ST_RUN);
      end
   end

   assign minutes  = r_minutes;
   assign seconds  = r_seconds;
   assign min_tick = r_min_tick;
   assign time_up  = r_time_up;
   assign running  = r_running;

endmodule

// File: tb/tb_game_minute_timer.sv
// Randomised scoreboard bench for game_minute_timer with a small timebase.
// The reference model tracks the total number of counting cycles and derives
// minutes/seconds from it arithmetically.
module tb_game_minute_timer;

   localparam int unsigned T   = 4;
   localparam int unsigned S   = 3;
   localparam int unsigned LIM = 5;
   localparam int unsigned MX  = 7;
   localparam int unsigned TPM  = T * S;
   localparam int unsigned FULL = MX * TPM;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Clear = 1'b0;
   logic       Run = 1'b0;
   logic [7:0] minutes;
   logic [5:0] seconds;
   logic       min_tick;
   logic       time_up;
   logic       running;

   game_minute_timer #(
      .TICKS_PER_SEC(T),
      .SEC_PER_MIN  (S),
      .LIMIT_MIN    (LIM),
      .MAX_MIN      (MX)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Clear   (Clear),
      .Run     (Run),
      .minutes (minutes),
      .seconds (seconds),
      .min_tick(min_tick),
      .time_up (time_up),
      .running (running)
   );

   always #5 Clk = ~Clk;

   // kind 0: output check, 1: mark min_tick base, 2: check min_tick pulses since mark
   typedef struct {
      time   t;
      int    kind;
      string tag;
      int    mn;
      int    sc;
      bit    mt;
      bit    tu;
      bit    rn;
      int    ticks;
   } exp_t;

   exp_t sb[$];
   event push_ev;

   int n_cmp = 0;
   int n_bad = 0;
   int mt_seen = 0;
   int mt_base = 0;

   // reference model state
   int n_cnt   = 0;
   bit armed   = 1'b0;
   bit last_inc = 1'b0;
   bit exp_mt  = 1'b0;

   function automatic void model_reset();
      n_cnt    = 0;
      armed    = 1'b0;
      last_inc = 1'b0;
      exp_mt   = 1'b0;
   endfunction

   function automatic void model_edge(input bit run, input bit clr, input bit rst);
      bit inc;
      int old_min;
      inc = 1'b0;
      if (rst) begin
         model_reset();
      end else begin
         exp_mt = clr ? 1'b0 : last_inc;
         if (clr) begin
            n_cnt = 0;
            armed = 1'b0;
         end else begin
            if (n_cnt < FULL && run && armed) begin
               old_min = n_cnt / TPM;
               n_cnt++;
               inc = ((n_cnt / TPM) != old_min);
            end
            armed = run;
         end
         last_inc = inc;
      end
   endfunction

   task automatic push_out(input time dt, input string tag, input bit imm);
      exp_t e;
      e.t     = $time + dt;
      e.kind  = 0;
      e.tag   = tag;
      e.mn    = n_cnt / TPM;
      e.sc    = (n_cnt % TPM) / T;
      e.mt    = imm ? 1'b0 : exp_mt;
      e.tu    = (n_cnt / TPM) >= LIM;
      e.rn    = imm ? 1'b0 : (armed && n_cnt < FULL);
      e.ticks = 0;
      sb.push_back(e);
      ->push_ev;
   endtask

   task automatic push_ctl(input int kind, input int ticks, input string tag);
      exp_t e;
      e.t     = $time + 7;
      e.kind  = kind;
      e.tag   = tag;
      e.mn    = 0;
      e.sc    = 0;
      e.mt    = 1'b0;
      e.tu    = 1'b0;
      e.rn    = 1'b0;
      e.ticks = ticks;
      sb.push_back(e);
      ->push_ev;
   endtask

   // one clock of stimulus, driven just after the falling edge
   task automatic step(input bit run, input bit clr, input bit rst, input string tag);
      @(negedge Clk);
      #1;
      if (rst && !Reset) begin
         Reset = 1'b1;
         model_reset();
         push_out(1, {tag, "_async"}, 1'b1);
      end
      Reset = rst;
      Run   = run;
      Clear = clr;
      model_edge(run, clr, rst);
      push_out(6, tag, 1'b0);
   endtask

   // monitor: pops expectations at their due time and compares
   initial begin
      exp_t e;
      forever begin
         if (sb.size() == 0) begin
            @(push_ev);
         end else begin
            e = sb[0];
            if ($time < e.t) #(e.t - $time);
            e = sb.pop_front();
            if (e.kind == 0) begin
               n_cmp++;
               if (minutes !== 8'(e.mn) || seconds !== 6'(e.sc) || min_tick !== e.mt ||
                   time_up !== e.tu || running !== e.rn) begin
                  n_bad++;
                  $display("FAIL %s @%0t: got min=%0d sec=%0d tick=%b up=%b run=%b, expected min=%0d sec=%0d tick=%b up=%b run=%b",
                           e.tag, $time, minutes, seconds, min_tick, time_up, running,
                           e.mn, e.sc, e.mt, e.tu, e.rn);
               end
               if (min_tick === 1'b1) mt_seen++;
            end else if (e.kind == 1) begin
               mt_base = mt_seen;
            end else begin
               n_cmp++;
               if (mt_seen - mt_base != e.ticks) begin
                  n_bad++;
                  $display("FAIL %s: got %0d min_tick pulses, expected %0d",
                           e.tag, mt_seen - mt_base, e.ticks);
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      step(0, 0, 1, "reset");
      step(0, 0, 1, "reset");

      // continuous run from reset through first minute, then pause at tick_cnt=2
      push_ctl(1, 0, "mark");
      step(1, 0, 0, "first_run");
      for (int i = 0; i < 200 && !(n_cnt > TPM && n_cnt % T == 2); i++)
         step(1, 0, 0, "run_to_pause");
      repeat (10) step(0, 0, 0, "pause");
      // run to saturation, then hold Run in DONE
      for (int i = 0; i < 300 && n_cnt < FULL; i++)
         step(1, 0, 0, "run_to_done");
      repeat (100) step(1, 0, 0, "done_hold");
      push_ctl(2, MX, "tick_total");

      // clear at minutes=3 seconds=2 with Run high
      step(1, 1, 0, "clear_done");
      for (int i = 0; i < 300 && !(n_cnt / TPM == 3 && (n_cnt % TPM) / T == 2); i++)
         step(1, 0, 0, "run_to_3m2s");
      step(1, 1, 0, "clear_run");
      repeat (3) step(1, 0, 0, "after_clear");

      // asynchronous reset at tick_cnt=3, then restart
      for (int i = 0; i < 20 && n_cnt % T != 3; i++)
         step(1, 0, 0, "run_to_t3");
      step(1, 0, 1, "mid_reset");
      for (int i = 0; i < TPM + 4; i++)
         step(1, 0, 0, "restart");

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         bit r, c, x;
         r = ($urandom_range(0, 9) != 0);
         c = ($urandom_range(0, 199) == 0);
         x = ($urandom_range(0, 299) == 0);
         step(r, c, x, "random");
      end

      repeat (3) step(0, 0, 0, "idle");
      #20;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
